// File: rtl/trigger_link_framer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// trigger_link_framer
//
// Purpose:
//   Splits NLINKS*CPL S-bit clusters into per-link frames. Valid clusters are
//   packed into the low slots of each link in their original order. Each
//   frame starts with a header that holds BC0, overflow, the valid count and
//   the low BX bits. The block also runs the TX PLL power-up sequencer
//   (powerdown -> reset -> lock wait -> ready). If lock is lost the
//   sequencer starts again from powerdown. Frames stay idle until the link
//   is ready.
//
// Ports:
//   clk_40              40 MHz logic clock (only clock)
//   reset_n             asynchronous active-low reset, released on clk_40
//   force_reset_i       one-cycle pulse, restarts the sequencer from PWRDN
//   clusters_i          NLINKS*CPL clusters; link k owns slots k*CPL..k*CPL+CPL-1
//   overflow_i          cluster overflow this BX
//   ttc_bx0_i           BC0 this BX
//   bxn_counter_i       BX number (only [2:0] goes into the header)
//   pll_lock_i          PLL lock, asynchronous to clk_40
//   pll_powerdown_o     PLL powerdown
//   pll_reset_o         PLL reset
//   link_ready_o        high while the sequencer is in READY
//   link_frame_o        per link {hdr[7:0], slot CPL-1 .. slot 0}
//   valid_clusters_o    registered per-slot valid flags (not compacted)
//   valid_clusters_or_o OR of the per-slot valid flags
//   retry_cnt_o         lock-timeout retries, saturating
//   lock_lost_cnt_o     lock losses seen in READY, saturating
// ---------------------------------------------------------------------------
module trigger_link_framer #(
    parameter int NLINKS       = 4,
    parameter int CPL          = 4,
    parameter int CB           = 14,
    parameter int PDCNT        = 96,
    parameter int RSTCNT       = 128,
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic                            clk_40,
    input  logic                            reset_n,
    input  logic                            force_reset_i,
    input  logic [NLINKS*CPL*CB-1:0]        clusters_i,
    input  logic                            overflow_i,
    input  logic                            ttc_bx0_i,
    input  logic [11:0]                     bxn_counter_i,
    input  logic                            pll_lock_i,
    output logic                            pll_powerdown_o,
    output logic                            pll_reset_o,
    output logic                            link_ready_o,
    output logic [NLINKS*(8+CPL*CB)-1:0]    link_frame_o,
    output logic [NLINKS*CPL-1:0]           valid_clusters_o,
    output logic                            valid_clusters_or_o,
    output logic [7:0]                      retry_cnt_o,
    output logic [7:0]                      lock_lost_cnt_o
);

    localparam int FW   = 8 + CPL*CB;
    localparam int NS   = NLINKS*CPL;
    localparam int CMAX = (PDCNT > RSTCNT) ?
                          ((PDCNT > LOCK_TIMEOUT) ? PDCNT : LOCK_TIMEOUT) :
                          ((RSTCNT > LOCK_TIMEOUT) ? RSTCNT : LOCK_TIMEOUT);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PD_LAST  = CW'(PDCNT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RSTCNT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);

    // An idle cluster has address field 2'b11. All of its low 11 bits are set.
    localparam logic [CB-1:0] IDLE_CL = CB'(11'h7FF);

    // Idle frame for every link: header zero and every slot idle.
    function automatic logic [NLINKS*FW-1:0] idle_frame();
        logic [NLINKS*FW-1:0] f;
        f = '0;
        for (int l = 0; l < NLINKS; l++)
            for (int j = 0; j < CPL; j++)
                f[l*FW + j*CB +: CB] = IDLE_CL;
        return f;
    endfunction

    localparam logic [NLINKS*FW-1:0] IDLE_FRAME = idle_frame();

    typedef enum logic [1:0] {
        ST_PWRDN,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_READY
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic                retry_evt, lost_evt;
    logic                lock_meta, lock_s;

    logic [NS*CB-1:0]    clusters_s1;
    logic                overflow_s1, bx0_s1;
    logic [2:0]          bxn_s1;
    logic [NS-1:0]       valid_in;
    logic [NLINKS*FW-1:0] frame_nxt;

    // Only the low three BX bits reach the header.
    logic unused_bxn;
    assign unused_bxn = ^bxn_counter_i[11:3];

    // Two-flop synchroniser for the PLL lock. pll_lock_i comes from the
    // MGT and is not related to clk_40. The sequencer looks only at lock_s.
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer state register. There is one shared counter. It clears on
    // every state entry. A forced restart also clears it, even when the
    // state is already PWRDN, so the full powerdown time is served again.
    // Both event counters saturate and only reset_n clears them.
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_PWRDN;
            cnt             <= '0;
            retry_cnt_o     <= 8'd0;
            lock_lost_cnt_o <= 8'd0;
        end else begin
            state <= state_nxt;
            if (force_reset_i || (state_nxt != state))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (retry_evt && (retry_cnt_o != 8'hFF))
                retry_cnt_o <= retry_cnt_o + 8'd1;
            if (lost_evt && (lock_lost_cnt_o != 8'hFF))
                lock_lost_cnt_o <= lock_lost_cnt_o + 8'd1;
        end
    end

    // Next-state logic. A forced restart takes priority over every other
    // transition, so it also blocks the retry and lock-lost events.
    always_comb begin
        state_nxt = state;
        retry_evt = 1'b0;
        lost_evt  = 1'b0;
        if (force_reset_i) begin
            state_nxt = ST_PWRDN;
        end else begin
            case (state)
                ST_PWRDN:
                    if (cnt == PD_LAST) state_nxt = ST_RESET;
                ST_RESET:
                    if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK:
                    if (lock_s) begin
                        state_nxt = ST_READY;
                    end else if (cnt == TO_LAST) begin
                        state_nxt = ST_PWRDN;
                        retry_evt = 1'b1;
                    end
                ST_READY:
                    if (!lock_s) begin
                        state_nxt = ST_PWRDN;
                        lost_evt  = 1'b1;
                    end
                default:
                    state_nxt = ST_PWRDN;
            endcase
        end
    end

    // Sequencer outputs, decoded from the state alone.
    always_comb begin
        pll_powerdown_o = (state == ST_PWRDN);
        pll_reset_o     = (state == ST_PWRDN) || (state == ST_RESET);
        link_ready_o    = (state == ST_READY);
    end

    // A slot is valid unless its address field [10:9] reads 2'b11.
    always_comb begin
        valid_in = '0;
        for (int s = 0; s < NS; s++)
            valid_in[s] = (clusters_i[s*CB + 9 +: 2] != 2'b11);
    end

    // First pipeline stage: register the inputs. The valid flags are
    // registered here too. They drive the valid outputs directly, one
    // cycle after the input, and they also drive the compaction stage.
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            clusters_s1         <= '0;
            overflow_s1         <= 1'b0;
            bx0_s1              <= 1'b0;
            bxn_s1              <= 3'd0;
            valid_clusters_o    <= '0;
            valid_clusters_or_o <= 1'b0;
        end else begin
            clusters_s1         <= clusters_i;
            overflow_s1         <= overflow_i;
            bx0_s1              <= ttc_bx0_i;
            bxn_s1              <= bxn_counter_i[2:0];
            valid_clusters_o    <= valid_in;
            valid_clusters_or_o <= |valid_in;
        end
    end

    // Second stage: compaction for each link. Every valid cluster goes to
    // the output slot given by the number of valid clusters already seen
    // on that link. The search over output slots uses constant indices, so
    // the logic is a plain mux tree. The remaining slots keep the idle value.
    always_comb begin
        int n;
        frame_nxt = '0;
        n         = 0;
        for (int l = 0; l < NLINKS; l++) begin
            n = 0;
            for (int j = 0; j < CPL; j++)
                frame_nxt[l*FW + j*CB +: CB] = IDLE_CL;
            for (int s = 0; s < CPL; s++) begin
                if (valid_clusters_o[l*CPL + s]) begin
                    for (int j = 0; j < CPL; j++)
                        if (j == n)
                            frame_nxt[l*FW + j*CB +: CB] = clusters_s1[(l*CPL + s)*CB +: CB];
                    n = n + 1;
                end
            end
            frame_nxt[l*FW + CPL*CB +: 8] = {bx0_s1, overflow_s1, 3'(n), bxn_s1};
        end
    end

    // Output frame register. The gate looks at link_ready_o in the capture
    // cycle. The edge that enters READY still captures an idle frame, and
    // the first data frame appears one cycle later.
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n)
            link_frame_o <= IDLE_FRAME;
        else if (link_ready_o)
            link_frame_o <= frame_nxt;
        else
            link_frame_o <= IDLE_FRAME;
    end

endmodule
